// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch buffer.
//   NOP_INST        - word shown on inst while the queue is empty
//   fetch_entry_t   - one queued {pc, inst} pair
//   FETCH_*         - default sizing and the matching counter widths
//   word_align()    - clears the two low address bits
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam int FETCH_DEPTH   = 4;
  localparam int FETCH_MAX_OUT = 2;
  localparam int FETCH_CNT_W   = $clog2(FETCH_DEPTH) + 1;
  localparam int FETCH_OUT_W   = $clog2(FETCH_MAX_OUT) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t.
//   clk, reset    - rising-edge clock, synchronous active-high reset
//   push, data_in - enqueue one entry
//   pop           - dequeue the head (ignored while empty)
//   flush         - drop all entries; wins over push and pop
//   head          - current head entry (undefined while empty)
//   full, empty, count - occupancy
// Push and pop together are legal at full: the freed slot is the one
// written, and the head is read before the edge.
import fetch_pkg::*;

module fetch_fifo #(
  parameter  int DEPTH = FETCH_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t data_in,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: prefetch queue between instruction memory and decode.
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   req_valid/addr/ready - sequential word fetch requests to memory
//   rsp_valid, rsp_data  - in-order read data from memory
//   redirect_valid/pc    - control-flow redirect; flushes the queue
//   inst_valid, inst, inst_pc, inst_ready - head entry handshake to decode
// A request is only issued when a queue slot is already reserved for its
// response, so responses never need back-pressure. After a redirect,
// responses still in flight belong to the old path and are counted off
// by discard_cnt before any new response is accepted.
import fetch_pkg::*;

module inst_fetch_buffer #(
  parameter int          DEPTH    = FETCH_DEPTH,
  parameter int          MAX_OUT  = FETCH_MAX_OUT,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT) + 1;

  logic [31:0]   fetch_pc, rsp_pc, last_pc;
  logic [OW-1:0] outstanding, discard_cnt;
  logic          fire, rsp_drop, push, pop;
  logic          full, empty;
  logic [CW-1:0] count;
  fetch_entry_t  head, push_entry;

  // Credit rule: count + outstanding < DEPTH reserves a slot per request.
  assign req_valid = !reset && !redirect_valid &&
                     (outstanding < OW'(MAX_OUT)) &&
                     ((int'(count) + int'(outstanding)) < DEPTH);
  assign req_addr  = fetch_pc;
  assign fire      = req_valid && req_ready;

  // Redirect-cycle responses are stale as well as counted discards.
  assign rsp_drop  = rsp_valid && ((discard_cnt != '0) || redirect_valid);
  assign push      = rsp_valid && !rsp_drop;
  assign pop       = inst_ready && !redirect_valid;

  assign push_entry.pc   = rsp_pc;
  assign push_entry.inst = rsp_data;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .data_in (push_entry),
    .pop     (pop),
    .flush   (redirect_valid),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign inst_valid = !empty;
  assign inst       = empty ? NOP_INST : head.inst;
  assign inst_pc    = empty ? last_pc  : head.pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      last_pc     <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding <= outstanding + OW'(fire) - OW'(rsp_valid);
      // Keeps inst_pc stable once the queue runs dry.
      if (!empty) last_pc <= head.pc;
      if (redirect_valid) begin
        fetch_pc    <= word_align(redirect_pc);
        rsp_pc      <= word_align(redirect_pc);
        discard_cnt <= outstanding - OW'(rsp_valid);
      end else begin
        if (fire) fetch_pc <= fetch_pc + 32'd4;
        if (push) rsp_pc   <= rsp_pc + 32'd4;
        if (rsp_valid && (discard_cnt != '0)) discard_cnt <= discard_cnt - OW'(1);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && full && !(pop && !empty)));

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: directed scenarios plus randomized traffic, checked
// each cycle against a queue-based reference model of the fetch buffer and
// an in-order memory model with random latency.
module tb_inst_fetch_buffer;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid, inst_valid;
  logic [31:0] req_addr, inst, inst_pc;
  logic        req_ready = 1'b0, rsp_valid = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
  logic [31:0] rsp_data = '0, redirect_pc = '0;

  always #5 clk = ~clk;

  inst_fetch_buffer #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  int checks = 0, failures = 0;
  int p_req = 100, p_rsp = 100, p_inst = 100;

  typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;
  logic [31:0] mp[$];   // memory: accepted, not yet returned addresses
  ent_t        mq[$];   // model of the decode-visible queue
  logic [31:0] m_fetch, m_rsp, m_last;
  int          m_disc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mp.delete(); mq.delete();
    m_fetch = RESET_PC; m_rsp = RESET_PC; m_last = RESET_PC; m_disc = 0;
  endtask

  // One clock: called just after a falling edge, returns at the next one.
  task automatic cyc(input bit redir, input logic [31:0] rpc);
    bit ev, rv, fire, pop, drop;
    logic [31:0] a, e_pc, e_inst;
    int pend;
    redirect_valid = redir;
    redirect_pc    = rpc;
    req_ready  = ($urandom_range(0, 99) < p_req);
    inst_ready = ($urandom_range(0, 99) < p_inst);
    rsp_valid  = (mp.size() > 0) && ($urandom_range(0, 99) < p_rsp);
    rsp_data   = rsp_valid ? word_of(mp[0]) : $urandom;
    #1;
    ev     = (mq.size() > 0);
    e_inst = ev ? mq[0].w  : NOP;
    e_pc   = ev ? mq[0].pc : m_last;
    rv     = !redir && (mp.size() < MAX_OUT) && ((mq.size() + mp.size()) < DEPTH);
    chk("inst_valid", inst_valid, ev);
    chk("inst", inst, e_inst);
    chk("inst_pc", inst_pc, e_pc);
    chk("req_valid", req_valid, rv);
    if (rv) chk("req_addr", req_addr, m_fetch);
    fire = rv && req_ready;
    pop  = ev && inst_ready && !redir;
    pend = mp.size();
    @(posedge clk);
    if (ev)  m_last = mq[0].pc;
    if (pop) void'(mq.pop_front());
    if (rsp_valid) begin
      a    = mp.pop_front();
      drop = (m_disc > 0) || redir;
      if (drop) begin
        if (m_disc > 0) m_disc--;
      end else begin
        mq.push_back('{m_rsp, word_of(a)});
        m_rsp += 32'd4;
      end
    end
    if (redir) begin
      mq.delete();
      m_fetch = {rpc[31:2], 2'b00};
      m_rsp   = m_fetch;
      m_disc  = pend - int'(rsp_valid);
    end else if (fire) begin
      mp.push_back(m_fetch);
      m_fetch += 32'd4;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0; rsp_valid = 1'b0; req_ready = 1'b0; inst_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, NOP);
    chk("rst_inst_pc", inst_pc, RESET_PC);
    reset = 1'b0;
    #1;
    chk("rst_first_req", req_valid, 1);
    chk("rst_first_addr", req_addr, RESET_PC);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (inst_valid === 1'b1) break;
      cyc(0, '0);
    end
    chk(tag, inst_valid, 1);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Steady streaming, one-cycle memory.
    p_req = 100; p_rsp = 100; p_inst = 100;
    cyc(0, '0);
    chk("t1_second_addr", req_addr, 32'h4);
    cyc(0, '0);
    chk("t1_first_valid", inst_valid, 1);
    chk("t1_first_pc", inst_pc, 32'h0);
    repeat (10) cyc(0, '0);

    // Decode stall fills the queue and blocks issue.
    p_inst = 0;
    repeat (12) cyc(0, '0);
    chk("t2_held", inst_valid, 1);
    chk("t2_req_blocked", req_valid, 0);
    p_inst = 100;
    repeat (12) cyc(0, '0);

    // Redirect with two requests in flight.
    p_req = 0; repeat (8) cyc(0, '0);
    p_rsp = 0; cyc(1, 32'h10);
    p_req = 100; cyc(0, '0); cyc(0, '0);
    chk("t3_two_issued", req_addr, 32'h18);
    cyc(1, 32'h200);
    p_rsp = 100;
    wait_valid("t3_valid");
    chk("t3_target_pc", inst_pc, 32'h200);

    // Redirect coinciding with a response.
    p_req = 0; repeat (8) cyc(0, '0);
    p_rsp = 0; cyc(1, 32'h40);
    p_req = 100; cyc(0, '0); cyc(0, '0);
    p_rsp = 100; cyc(1, 32'h300);
    wait_valid("t4_valid");
    chk("t4_target_pc", inst_pc, 32'h300);

    // Alignment and address wrap.
    cyc(1, 32'h103);
    chk("t5_align", req_addr, 32'h100);
    cyc(1, 32'hFFFF_FFFC);
    chk("t5_top", req_addr, 32'hFFFF_FFFC);
    wait_valid("t5_valid_top");
    chk("t5_pc_top", inst_pc, 32'hFFFF_FFFC);
    cyc(0, '0);
    wait_valid("t5_valid_wrap");
    chk("t5_pc_wrap", inst_pc, 32'h0);

    // Reset with entries queued and requests in flight.
    p_inst = 0; p_req = 100; p_rsp = 100;
    for (int i = 0; i < 20; i++) begin
      if (mq.size() >= 2) break;
      cyc(0, '0);
    end
    p_rsp = 0;
    repeat (3) cyc(0, '0);
    do_reset();

    // Randomized traffic with occasional redirects.
    for (int i = 0; i < 600; i++) begin
      if (i % 25 == 0) begin
        p_req  = $urandom_range(20, 100);
        p_rsp  = $urandom_range(20, 100);
        p_inst = $urandom_range(0, 100);
      end
      if ($urandom_range(0, 99) < 4) cyc(1, $urandom);
      else cyc(0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
